hex_digit_entry: RTL and testbench

- Sequential digit-entry register: the write side of the 8-digit multiplexed hex display path.
- Collects 4-bit hex digits one at a time from keypad or switch strobes and shifts them into a 32-bit live edit word.
- Supports backspace and clear; commits the word on enter.
- The display mux scans either the live word (HEX_edit) or the committed word (HEX_out), one nibble per digit slot.

---
 rtl/hex_digit_entry.sv | 168 ++++++++++++++++
 tb/tb_hex_digit_entry.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_digit_entry.sv
// hex_digit_entry: write side of the multiplexed hex display path.
// Hex digits are shifted into a live edit word one strobe at a time; the
// word can be trimmed (backspace), discarded (clear) or committed (enter).
// Each control input is a level; only its rising edge performs an action.
// At most one action happens per cycle, priority clear > enter > backspace
// > digit, and lower-priority edges in that cycle are dropped.
module hex_digit_entry #(
  parameter int NUM_DIGITS  = 8,    // 2..8
  parameter bit AUTO_COMMIT = 1'b0  // commit as soon as the last slot fills
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [3:0]              digit_in,
  input  logic                    digit_stb,
  input  logic                    enter,
  input  logic                    backspace,
  input  logic                    clear,
  output logic [4*NUM_DIGITS-1:0] HEX_edit,
  output logic [4*NUM_DIGITS-1:0] HEX_out,
  output logic [3:0]              count,
  output logic                    full,
  output logic                    commit,
  output logic                    reject
);

  localparam int         W       = 4 * NUM_DIGITS;
  localparam logic [3:0] CNT_MAX = 4'(NUM_DIGITS);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_nx;
  logic [W-1:0]   r_edit;
  logic [W-1:0]   r_out;
  logic [W-1:0]   w_edit_nx;
  logic [W-1:0]   w_out_nx;
  logic [W-1:0]   w_edit_push;
  logic [W-1:0]   w_edit_pop;
  logic [3:0]     r_count;
  logic [3:0]     w_count_nx;
  logic [3:0]     w_count_inc;
  logic [3:0]     w_count_dec;
  logic           r_commit;
  logic           r_reject;
  logic           w_commit_nx;
  logic           w_reject_nx;

  // previous-sample history for edge detection
  logic           r_stb_d;
  logic           r_enter_d;
  logic           r_bs_d;
  logic           r_clear_d;
  logic           w_ev_stb;
  logic           w_ev_enter;
  logic           w_ev_bs;
  logic           w_ev_clear;

  assign w_ev_stb   = digit_stb & ~r_stb_d;
  assign w_ev_enter = enter     & ~r_enter_d;
  assign w_ev_bs    = backspace & ~r_bs_d;
  assign w_ev_clear = clear     & ~r_clear_d;

  // Newest digit always lands in the low nibble; backspace drops it and
  // shifts zero into the top nibble.
  assign w_edit_push = {r_edit[W-5:0], digit_in};
  assign w_edit_pop  = {4'h0, r_edit[W-1:4]};
  assign w_count_inc = r_count + 4'd1;
  assign w_count_dec = r_count - 4'd1;

  // Sample the control inputs once per cycle to form single-shot edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stb_d   <= 1'b0;
      r_enter_d <= 1'b0;
      r_bs_d    <= 1'b0;
      r_clear_d <= 1'b0;
    end else begin
      r_stb_d   <= digit_stb;
      r_enter_d <= enter;
      r_bs_d    <= backspace;
      r_clear_d <= clear;
    end
  end

  // Pick the single winning action and compute the next word, count and
  // state; the pulses default low so they last exactly one cycle.
  always_comb begin
    w_state_nx  = r_state;
    w_edit_nx   = r_edit;
    w_out_nx    = r_out;
    w_count_nx  = r_count;
    w_commit_nx = 1'b0;
    w_reject_nx = 1'b0;

    if (w_ev_clear) begin
      w_edit_nx  = '0;
      w_count_nx = 4'd0;
      w_state_nx = ST_EMPTY;
    end else if (w_ev_enter) begin
      // Committing an empty word is legal and publishes zero.
      w_out_nx    = r_edit;
      w_commit_nx = 1'b1;
      w_edit_nx   = '0;
      w_count_nx  = 4'd0;
      w_state_nx  = ST_EMPTY;
    end else if (w_ev_bs) begin
      if (r_state == ST_EMPTY) begin
        w_reject_nx = 1'b1;
      end else begin
        w_edit_nx  = w_edit_pop;
        w_count_nx = w_count_dec;
        w_state_nx = (w_count_dec == 4'd0) ? ST_EMPTY : ST_PARTIAL;
      end
    end else if (w_ev_stb) begin
      if (r_state == ST_FULL) begin
        w_reject_nx = 1'b1;
      end else if (w_count_inc == CNT_MAX) begin
        if (AUTO_COMMIT) begin
          // The last digit publishes the word directly; FULL is never held.
          w_out_nx    = w_edit_push;
          w_commit_nx = 1'b1;
          w_edit_nx   = '0;
          w_count_nx  = 4'd0;
          w_state_nx  = ST_EMPTY;
        end else begin
          w_edit_nx  = w_edit_push;
          w_count_nx = w_count_inc;
          w_state_nx = ST_FULL;
        end
      end else begin
        w_edit_nx  = w_edit_push;
        w_count_nx = w_count_inc;
        w_state_nx = ST_PARTIAL;
      end
    end
  end

  // State, data and pulse registers; reset clears the committed word too.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_EMPTY;
      r_edit   <= '0;
      r_out    <= '0;
      r_count  <= 4'd0;
      r_commit <= 1'b0;
      r_reject <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_edit   <= w_edit_nx;
      r_out    <= w_out_nx;
      r_count  <= w_count_nx;
      r_commit <= w_commit_nx;
      r_reject <= w_reject_nx;
    end
  end

  assign HEX_edit = r_edit;
  assign HEX_out  = r_out;
  assign count    = r_count;
  assign full     = (r_count == CNT_MAX);
  assign commit   = r_commit;
  assign reject   = r_reject;

endmodule

// File: tb/tb_hex_digit_entry.sv
// Bench for hex_digit_entry: an 8-digit manual-commit instance and a 4-digit
// auto-commit instance share one stimulus stream. A digit-list model tracks
// both and is compared every cycle; directed literal checks pin the model.
module tb_hex_digit_entry;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  digit_in = 4'h0;
  logic        digit_stb = 1'b0;
  logic        enter = 1'b0;
  logic        backspace = 1'b0;
  logic        clear = 1'b0;

  logic [31:0] e8, o8;
  logic [3:0]  c8;
  logic        f8, cm8, rj8;
  logic [15:0] e4, o4;
  logic [3:0]  c4;
  logic        f4, cm4, rj4;

  int checks = 0;
  int failures = 0;

  hex_digit_entry #(.NUM_DIGITS(8), .AUTO_COMMIT(1'b0)) u_d8 (
    .clk(clk), .reset(reset), .digit_in(digit_in), .digit_stb(digit_stb),
    .enter(enter), .backspace(backspace), .clear(clear),
    .HEX_edit(e8), .HEX_out(o8), .count(c8), .full(f8), .commit(cm8), .reject(rj8)
  );

  hex_digit_entry #(.NUM_DIGITS(4), .AUTO_COMMIT(1'b1)) u_d4 (
    .clk(clk), .reset(reset), .digit_in(digit_in), .digit_stb(digit_stb),
    .enter(enter), .backspace(backspace), .clear(clear),
    .HEX_edit(e4), .HEX_out(o4), .count(c4), .full(f4), .commit(cm4), .reject(rj4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: the edit word is a list of entered digits, oldest first.
  typedef struct packed {
    logic [3:0]      len;
    logic [7:0][3:0] dig;
    logic [31:0]     out;
    logic            commit;
    logic            reject;
    logic            p_stb;
    logic            p_ent;
    logic            p_bs;
    logic            p_clr;
  } model_t;

  model_t m8 = '0;
  model_t m4 = '0;

  function automatic logic [31:0] word_of(input model_t m);
    logic [31:0] w = 32'h0;
    for (int i = 0; i < int'(m.len); i++) w = (w << 4) | 32'(m.dig[i]);
    return w;
  endfunction

  function automatic model_t step(input model_t mi, input int n, input bit ac,
                                  input logic [3:0] d, input logic stb, input logic ent,
                                  input logic bs, input logic clr);
    model_t m = mi;
    bit e_stb = stb && !m.p_stb;
    bit e_ent = ent && !m.p_ent;
    bit e_bs  = bs  && !m.p_bs;
    bit e_clr = clr && !m.p_clr;
    m.p_stb = stb; m.p_ent = ent; m.p_bs = bs; m.p_clr = clr;
    m.commit = 1'b0;
    m.reject = 1'b0;
    if (e_clr) begin
      m.len = 4'd0;
    end else if (e_ent) begin
      m.out = word_of(m);
      m.commit = 1'b1;
      m.len = 4'd0;
    end else if (e_bs) begin
      if (m.len == 4'd0) m.reject = 1'b1;
      else m.len = m.len - 4'd1;
    end else if (e_stb) begin
      if (int'(m.len) == n) begin
        m.reject = 1'b1;
      end else begin
        m.dig[m.len] = d;
        m.len = m.len + 4'd1;
        if (ac && int'(m.len) == n) begin
          m.out = word_of(m);
          m.commit = 1'b1;
          m.len = 4'd0;
        end
      end
    end
    return m;
  endfunction

  // Advance the model on each edge (or clear it immediately on reset).
  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m8 = '0;
        m4 = '0;
      end else begin
        m8 = step(m8, 8, 1'b0, digit_in, digit_stb, enter, backspace, clear);
        m4 = step(m4, 4, 1'b1, digit_in, digit_stb, enter, backspace, clear);
      end
    end
  end

  // Compare every output of both instances mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      chk("d8_edit",   e8,          word_of(m8));
      chk("d8_out",    o8,          m8.out);
      chk("d8_count",  32'(c8),     32'(m8.len));
      chk("d8_full",   32'(f8),     32'(m8.len == 4'd8));
      chk("d8_commit", 32'(cm8),    32'(m8.commit));
      chk("d8_reject", 32'(rj8),    32'(m8.reject));
      chk("d4_edit",   32'(e4),     word_of(m4));
      chk("d4_out",    32'(o4),     m4.out);
      chk("d4_count",  32'(c4),     32'(m4.len));
      chk("d4_full",   32'(f4),     32'(m4.len == 4'd4));
      chk("d4_commit", 32'(cm4),    32'(m4.commit));
      chk("d4_reject", 32'(rj4),    32'(m4.reject));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Each action task returns just after the edge that acted on it.
  task automatic do_digit(input logic [3:0] d);
    tick();
    digit_in = d;
    digit_stb = 1'b1;
    tick();
    digit_stb = 1'b0;
  endtask

  task automatic do_bs();
    tick(); backspace = 1'b1; tick(); backspace = 1'b0;
  endtask

  task automatic do_enter();
    tick(); enter = 1'b1; tick(); enter = 1'b0;
  endtask

  task automatic do_clear();
    tick(); clear = 1'b1; tick(); clear = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_edit",   e8,       32'h0);
    chk("rst_out",    o8,       32'h0);
    chk("rst_count",  32'(c8),  32'h0);
    chk("rst_commit", 32'(cm8), 32'h0);
    chk("rst_reject", 32'(rj8), 32'h0);
    reset = 1'b0;

    // Digits 1..4
    for (int i = 1; i <= 4; i++) do_digit(4'(i));
    chk("four_auto_commit", 32'(cm4), 32'h1);
    chk("four_auto_out",    32'(o4),  32'h1234);
    chk("four_edit",  e8,      32'h0000_1234);
    chk("four_count", 32'(c8), 32'd4);
    chk("four_full",  32'(f8), 32'h0);

    // Fill 8 digits then overflow
    do_clear();
    for (int i = 1; i <= 8; i++) do_digit(4'(i));
    chk("fill_edit",  e8,      32'h1234_5678);
    chk("fill_full",  32'(f8), 32'h1);
    chk("fill_count", 32'(c8), 32'd8);
    do_digit(4'h9);
    chk("ovf_reject", 32'(rj8), 32'h1);
    chk("ovf_edit",   e8,       32'h1234_5678);
    tick();
    chk("ovf_reject_end", 32'(rj8), 32'h0);
    chk("ovf_edit_hold",  e8,       32'h1234_5678);

    // Backspace down through empty
    do_clear();
    do_digit(4'hA); do_digit(4'hB); do_digit(4'hC);
    chk("bs_start", e8, 32'h0000_0ABC);
    do_bs();
    chk("bs1_edit", e8, 32'h0000_00AB); chk("bs1_count", 32'(c8), 32'd2);
    do_bs();
    chk("bs2_edit", e8, 32'h0000_000A); chk("bs2_count", 32'(c8), 32'd1);
    do_bs();
    chk("bs3_edit", e8, 32'h0); chk("bs3_count", 32'(c8), 32'd0);
    chk("bs3_reject", 32'(rj8), 32'h0);
    do_bs();
    chk("bs4_reject", 32'(rj8), 32'h1); chk("bs4_count", 32'(c8), 32'd0);

    // Commit BEEF, then clear leaves HEX_out alone
    do_clear();
    do_digit(4'hB); do_digit(4'hE); do_digit(4'hE); do_digit(4'hF);
    chk("beef_auto_commit", 32'(cm4), 32'h1);
    chk("beef_auto_out",    32'(o4),  32'hBEEF);
    do_enter();
    chk("enter_commit", 32'(cm8), 32'h1);
    chk("enter_out",    o8,       32'h0000_BEEF);
    chk("enter_edit",   e8,       32'h0);
    chk("enter_count",  32'(c8),  32'd0);
    tick();
    chk("enter_commit_end", 32'(cm8), 32'h0);
    do_clear();
    chk("clear_keeps_out", o8, 32'h0000_BEEF);

    // Enter and digit rising together: enter wins, digit dropped
    do_digit(4'h1); do_digit(4'h2);
    tick();
    digit_in = 4'h3; digit_stb = 1'b1; enter = 1'b1;
    tick();
    chk("prio_out",    o8,       32'h0000_0012);
    chk("prio_commit", 32'(cm8), 32'h1);
    chk("prio_count",  32'(c8),  32'd0);
    enter = 1'b0; digit_stb = 1'b0;

    // Held strobe produces a single digit
    tick();
    digit_in = 4'h5; digit_stb = 1'b1;
    repeat (10) tick();
    chk("held_count", 32'(c8), 32'd1);
    chk("held_edit",  e8,      32'h0000_0005);
    digit_stb = 1'b0;

    // Auto-commit on the 4th digit
    do_clear();
    do_digit(4'hA); do_digit(4'hB); do_digit(4'hC); do_digit(4'hD);
    chk("auto_commit", 32'(cm4), 32'h1);
    chk("auto_out",    32'(o4),  32'hABCD);
    chk("auto_count",  32'(c4),  32'd0);
    chk("auto_edit",   32'(e4),  32'h0);

    // Reset mid-entry acts before the next clock edge
    do_digit(4'h1); do_digit(4'h2);
    reset = 1'b1;
    #2;
    chk("arst_d8_edit",  e8,      32'h0);
    chk("arst_d8_out",   o8,      32'h0);
    chk("arst_d8_count", 32'(c8), 32'h0);
    chk("arst_d4_edit",  32'(e4), 32'h0);
    chk("arst_d4_out",   32'(o4), 32'h0);

    // Strobe already high when reset releases counts as an edge
    digit_in = 4'h7; digit_stb = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("post_rst_count", 32'(c8), 32'd1);
    chk("post_rst_edit",  e8,      32'h0000_0007);
    digit_stb = 1'b0;

    // Clear beats backspace in the same cycle
    do_digit(4'h3);
    tick();
    clear = 1'b1; backspace = 1'b1;
    tick();
    chk("clr_bs_edit",   e8,       32'h0);
    chk("clr_bs_reject", 32'(rj8), 32'h0);
    clear = 1'b0; backspace = 1'b0;
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
